// File: rtl/game_flow_if.sv
// Bundles the key, collision and position inputs of the game flow controller
// with its state, status and control outputs.
interface game_flow_if #(
    parameter int NUM_LEVELS = 4,
    parameter int NUM_PU     = 3
);
    localparam int LW  = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
    localparam int PTW = $clog2(NUM_PU + 1);

    logic              startKey;
    logic              pauseKey;
    logic              fireKey;
    logic              rightArrow;
    logic              leftArrow;
    logic              col_player_ball;
    logic              col_rope_ball;
    logic              col_present;
    logic              ballsCleared;
    logic [PTW-1:0]    presentType;
    logic [10:0]       playerX;
    logic [10:0]       ropeTopY;
    logic              secClk;

    logic [2:0]        gameState;
    logic [LW-1:0]     level;
    logic [3:0]        lives;
    logic [11:0]       gameTime;
    logic [NUM_PU-1:0] puActive;
    logic              ropeActive;
    logic [10:0]       ropeX;
    logic              playerMoveRight;
    logic              playerMoveLeft;
    logic              playerReset;
    logic              presentDrop;
    logic              playerVisible;
    logic              ballVisible;
    logic              presentsVisible;
    logic              gameWon;

    modport master (
        output startKey, pauseKey, fireKey, rightArrow, leftArrow,
               col_player_ball, col_rope_ball, col_present, ballsCleared,
               presentType, playerX, ropeTopY, secClk,
        input  gameState, level, lives, gameTime, puActive, ropeActive, ropeX,
               playerMoveRight, playerMoveLeft, playerReset, presentDrop,
               playerVisible, ballVisible, presentsVisible, gameWon
    );

    modport slave (
        input  startKey, pauseKey, fireKey, rightArrow, leftArrow,
               col_player_ball, col_rope_ball, col_present, ballsCleared,
               presentType, playerX, ropeTopY, secClk,
        output gameState, level, lives, gameTime, puActive, ropeActive, ropeX,
               playerMoveRight, playerMoveLeft, playerReset, presentDrop,
               playerVisible, ballVisible, presentsVisible, gameWon
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game flow controller: sequences welcome/play/pause/level/game-over, owns lives,
// level, game time, the rope and a bank of timed power-up channels.
module game_flow_ctrl #(
    parameter int INITIAL_LIVES = 3,
    parameter int MAX_LIVES     = 7,
    parameter int NUM_LEVELS    = 4,
    parameter int NUM_PU        = 3,
    parameter int PU_DURATION   = 5,
    parameter int HIT_GRACE     = 3,
    parameter int DROP_PERIOD   = 3
) (
    input  logic         clk,
    input  logic         resetN,
    game_flow_if.slave   bus
);
    localparam int LW    = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
    localparam int PTW   = $clog2(NUM_PU + 1);
    localparam int TMAX  = (PU_DURATION > HIT_GRACE) ? PU_DURATION : HIT_GRACE;
    localparam int TW    = $clog2(TMAX + 1);
    localparam int DW    = (DROP_PERIOD > 1) ? $clog2(DROP_PERIOD) : 1;

    localparam logic [LW-1:0] LAST_LEVEL = LW'(NUM_LEVELS - 1);
    localparam logic [3:0]    INIT_L     = 4'(INITIAL_LIVES);
    localparam logic [3:0]    MAX_L      = 4'(MAX_LIVES);
    localparam logic [TW-1:0] PU_T       = TW'(PU_DURATION);
    localparam logic [TW-1:0] GRACE_T    = TW'(HIT_GRACE);
    localparam logic [DW-1:0] DROP_LAST  = DW'(DROP_PERIOD - 1);

    typedef enum logic [2:0] {
        S_WELCOME    = 3'd0,
        S_PLAY       = 3'd1,
        S_PAUSE      = 3'd2,
        S_LEVEL_DONE = 3'd3,
        S_GAME_OVER  = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        lives_q, lives_d;
    logic [LW-1:0]     level_q, level_d;
    logic [11:0]       time_q, time_d;
    logic [DW-1:0]     drop_cnt_q, drop_cnt_d;
    logic [TW-1:0]     timer_q [NUM_PU];
    logic [TW-1:0]     timer_d [NUM_PU];
    logic [NUM_PU-1:0] pu_q, pu_d;
    logic              rope_act_q, rope_act_d;
    logic [10:0]       rope_x_q, rope_x_d;
    logic              won_q, won_d;
    logic              p_reset_q, p_reset_d;
    logic              drop_q, drop_d;
    logic              move_r_q, move_r_d;
    logic              move_l_q, move_l_d;
    logic              vis_q, vis_d;

    logic in_play;
    logic hit;
    logic extra;

    assign in_play = (state_q == S_PLAY);
    // A hit only counts when immortality is not running.
    assign hit     = in_play && bus.col_player_ball && !pu_q[0];
    assign extra   = in_play && bus.col_present && (bus.presentType == '0);

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q <= S_WELCOME;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WELCOME: begin
                if (bus.startKey) state_d = S_PLAY;
            end
            S_PLAY: begin
                if (lives_q == 4'd0)       state_d = S_GAME_OVER;
                else if (bus.ballsCleared) state_d = S_LEVEL_DONE;
                else if (bus.pauseKey)     state_d = S_PAUSE;
            end
            S_PAUSE: begin
                if (bus.pauseKey) state_d = S_PLAY;
            end
            S_LEVEL_DONE: begin
                if (bus.startKey) state_d = (level_q != LAST_LEVEL) ? S_PLAY : S_GAME_OVER;
            end
            S_GAME_OVER: begin
                if (bus.startKey) state_d = S_WELCOME;
            end
            default: state_d = S_WELCOME;
        endcase
    end

    always_comb begin
        lives_d    = lives_q;
        level_d    = level_q;
        time_d     = time_q;
        drop_cnt_d = drop_cnt_q;
        rope_act_d = rope_act_q;
        rope_x_d   = rope_x_q;
        won_d      = won_q;
        p_reset_d  = 1'b0;
        drop_d     = 1'b0;
        move_r_d   = (state_d == S_PLAY) && bus.rightArrow;
        move_l_d   = (state_d == S_PLAY) && bus.leftArrow;
        vis_d      = (state_d == S_PLAY) || (state_d == S_PAUSE);
        for (int k = 0; k < NUM_PU; k++) begin
            timer_d[k] = timer_q[k];
        end

        if (hit && !extra) begin
            lives_d = (lives_q != 4'd0) ? lives_q - 4'd1 : 4'd0;
        end else if (extra && !hit) begin
            lives_d = (lives_q < MAX_L) ? lives_q + 4'd1 : MAX_L;
        end
        p_reset_d = hit;

        // A fresh grant overrides both the rope-hit clear and the per-second decrement.
        for (int k = 0; k < NUM_PU; k++) begin
            if (in_play) begin
                if (bus.col_present && (bus.presentType == PTW'(k + 1))) begin
                    timer_d[k] = PU_T;
                end else if ((k == 0) && hit) begin
                    timer_d[k] = GRACE_T;
                end else if ((k == 1) && bus.col_rope_ball) begin
                    timer_d[k] = '0;
                end else if (bus.secClk && (timer_q[k] != '0)) begin
                    timer_d[k] = timer_q[k] - TW'(1);
                end
            end
        end

        if (in_play) begin
            if (bus.col_rope_ball) begin
                rope_act_d = 1'b0;
            end else if (rope_act_q && (bus.ropeTopY == 11'd0) && !pu_q[1]) begin
                rope_act_d = 1'b0;
            end else if (bus.fireKey && !rope_act_q) begin
                rope_act_d = 1'b1;
                rope_x_d   = bus.playerX;
            end

            if (bus.secClk) begin
                time_d = time_q + 12'd1;
                if (drop_cnt_q == DROP_LAST) begin
                    drop_cnt_d = '0;
                    drop_d     = 1'b1;
                end else begin
                    drop_cnt_d = drop_cnt_q + DW'(1);
                end
            end
        end

        if ((state_q == S_LEVEL_DONE) && (state_d != S_LEVEL_DONE)) begin
            rope_act_d = 1'b0;
            p_reset_d  = 1'b1;
            if (level_q != LAST_LEVEL) level_d = level_q + LW'(1);
            else                       won_d   = 1'b1;
        end

        if (state_d == S_WELCOME) begin
            lives_d    = INIT_L;
            level_d    = '0;
            time_d     = '0;
            won_d      = 1'b0;
            rope_act_d = 1'b0;
            for (int k = 0; k < NUM_PU; k++) begin
                timer_d[k] = '0;
            end
        end

        for (int k = 0; k < NUM_PU; k++) begin
            pu_d[k] = (timer_d[k] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            lives_q    <= INIT_L;
            level_q    <= '0;
            time_q     <= '0;
            drop_cnt_q <= '0;
            for (int k = 0; k < NUM_PU; k++) begin
                timer_q[k] <= '0;
            end
            pu_q       <= '0;
            rope_act_q <= 1'b0;
            rope_x_q   <= '0;
            won_q      <= 1'b0;
            p_reset_q  <= 1'b0;
            drop_q     <= 1'b0;
            move_r_q   <= 1'b0;
            move_l_q   <= 1'b0;
            vis_q      <= 1'b0;
        end else begin
            lives_q    <= lives_d;
            level_q    <= level_d;
            time_q     <= time_d;
            drop_cnt_q <= drop_cnt_d;
            for (int k = 0; k < NUM_PU; k++) begin
                timer_q[k] <= timer_d[k];
            end
            pu_q       <= pu_d;
            rope_act_q <= rope_act_d;
            rope_x_q   <= rope_x_d;
            won_q      <= won_d;
            p_reset_q  <= p_reset_d;
            drop_q     <= drop_d;
            move_r_q   <= move_r_d;
            move_l_q   <= move_l_d;
            vis_q      <= vis_d;
        end
    end

    assign bus.gameState       = state_q;
    assign bus.level           = level_q;
    assign bus.lives           = lives_q;
    assign bus.gameTime        = time_q;
    assign bus.puActive        = pu_q;
    assign bus.ropeActive      = rope_act_q;
    assign bus.ropeX           = rope_x_q;
    assign bus.playerMoveRight = move_r_q;
    assign bus.playerMoveLeft  = move_l_q;
    assign bus.playerReset     = p_reset_q;
    assign bus.presentDrop     = drop_q;
    assign bus.playerVisible   = vis_q;
    assign bus.ballVisible     = vis_q;
    assign bus.presentsVisible = vis_q;
    assign bus.gameWon         = won_q;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with two levels and three power-up channels.
module tb_game_flow_ctrl;
    logic clk = 1'b0;
    logic resetN = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    game_flow_if #(.NUM_LEVELS(2), .NUM_PU(3)) bus ();

    game_flow_ctrl #(
        .INITIAL_LIVES(3), .MAX_LIVES(7), .NUM_LEVELS(2), .NUM_PU(3),
        .PU_DURATION(5), .HIT_GRACE(3), .DROP_PERIOD(3)
    ) dut (
        .clk   (clk),
        .resetN(resetN),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus.startKey        = 1'b0;
        bus.pauseKey        = 1'b0;
        bus.fireKey         = 1'b0;
        bus.col_player_ball = 1'b0;
        bus.col_rope_ball   = 1'b0;
        bus.col_present     = 1'b0;
        bus.ballsCleared    = 1'b0;
        bus.secClk          = 1'b0;
    endtask

    task automatic sec();
        bus.secClk = 1'b1;
        step();
    endtask

    task automatic secs(input int n);
        for (int i = 0; i < n; i++) sec();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int drops;
        bus.startKey = 0; bus.pauseKey = 0; bus.fireKey = 0;
        bus.rightArrow = 0; bus.leftArrow = 0;
        bus.col_player_ball = 0; bus.col_rope_ball = 0; bus.col_present = 0;
        bus.ballsCleared = 0; bus.presentType = 0;
        bus.playerX = 11'd0; bus.ropeTopY = 11'd100; bus.secClk = 0;

        step(); step();
        chk("rst_state", bus.gameState, 0);
        chk("rst_lives", bus.lives, 3);
        chk("rst_level", bus.level, 0);
        chk("rst_time", bus.gameTime, 0);
        chk("rst_pu", bus.puActive, 0);
        chk("rst_rope", bus.ropeActive, 0);
        chk("rst_ropex", bus.ropeX, 0);
        chk("rst_won", bus.gameWon, 0);
        chk("rst_vis", bus.playerVisible, 0);
        resetN = 1'b1;

        // Start, move, fire
        bus.startKey = 1; step();
        chk("start_state", bus.gameState, 1);
        chk("start_vis", {bus.playerVisible, bus.ballVisible, bus.presentsVisible}, 3'b111);
        bus.rightArrow = 1; step();
        chk("move_right", bus.playerMoveRight, 1);
        bus.rightArrow = 0;
        bus.playerX = 11'd200; bus.fireKey = 1; step();
        chk("fire_rope", bus.ropeActive, 1);
        chk("fire_x", bus.ropeX, 200);
        bus.playerX = 11'd300; bus.fireKey = 1; step();
        chk("refire_x", bus.ropeX, 200);
        bus.ropeTopY = 11'd0; step();
        chk("rope_top", bus.ropeActive, 0);
        bus.ropeTopY = 11'd100;

        // Time and drops
        sec(); chk("time1", bus.gameTime, 1); chk("drop1", bus.presentDrop, 0);
        sec(); chk("drop2", bus.presentDrop, 0);
        sec(); chk("time3", bus.gameTime, 3); chk("drop3", bus.presentDrop, 1);
        step(); chk("drop_width", bus.presentDrop, 0);

        // Pause freezes time, timers, drop counter
        bus.col_present = 1; bus.presentType = 2'd3; step();
        chk("pu2_grant", bus.puActive, 3'b100);
        bus.rightArrow = 1; bus.pauseKey = 1; step();
        chk("pause_state", bus.gameState, 2);
        chk("pause_vis", bus.playerVisible, 1);
        drops = 0;
        for (int i = 0; i < 10; i++) begin
            sec();
            drops += int'(bus.presentDrop);
        end
        chk("pause_move", bus.playerMoveRight, 0);
        chk("pause_time", bus.gameTime, 3);
        chk("pause_pu", bus.puActive, 3'b100);
        chk("pause_drops", drops, 0);
        bus.rightArrow = 0; bus.pauseKey = 1; step();
        chk("unpause", bus.gameState, 1);
        sec(); sec(); chk("resume_nodrop", bus.presentDrop, 0);
        sec(); chk("resume_time", bus.gameTime, 6); chk("resume_drop", bus.presentDrop, 1);
        chk("resume_pu", bus.puActive, 3'b100);
        secs(2); chk("pu2_expire", bus.puActive, 3'b000);

        // Super rope window
        bus.col_present = 1; bus.presentType = 2'd2; step();
        chk("pu1_grant", bus.puActive, 3'b010);
        bus.playerX = 11'd50; bus.fireKey = 1; step();
        bus.ropeTopY = 11'd0; step();
        chk("super_rope", bus.ropeActive, 1);
        for (int i = 0; i < 5; i++) begin
            sec();
            chk("pu1_window", bus.puActive[1], (i < 4) ? 1 : 0);
        end
        chk("super_rope_hold", bus.ropeActive, 1);
        step(); chk("super_rope_end", bus.ropeActive, 0);
        bus.ropeTopY = 11'd100;

        // Grant coincident with secClk reloads to full duration
        bus.col_present = 1; bus.presentType = 2'd2; bus.secClk = 1; step();
        secs(4); chk("coinc_4", bus.puActive[1], 1);
        sec(); chk("coinc_5", bus.puActive[1], 0);
        bus.col_present = 1; bus.presentType = 2'd2; step();
        bus.fireKey = 1; step();
        bus.col_rope_ball = 1; step();
        chk("rope_ball_rope", bus.ropeActive, 0);
        chk("rope_ball_pu1", bus.puActive[1], 0);

        // Hit and grace
        bus.col_player_ball = 1; step();
        chk("hit_lives", bus.lives, 2);
        chk("hit_imm", bus.puActive[0], 1);
        chk("hit_preset", bus.playerReset, 1);
        step(); chk("preset_width", bus.playerReset, 0);
        sec();
        bus.col_player_ball = 1; step();
        chk("grace_lives", bus.lives, 2);
        secs(2); chk("grace_end", bus.puActive[0], 0);

        // Hit plus extra life
        bus.col_player_ball = 1; bus.col_present = 1; bus.presentType = 2'd0; step();
        chk("simul_lives", bus.lives, 2);
        chk("simul_imm", bus.puActive[0], 1);
        secs(3);

        // Saturation
        for (int i = 0; i < 5; i++) begin
            bus.col_present = 1; bus.presentType = 2'd0; step();
        end
        chk("lives_7", bus.lives, 7);
        bus.col_present = 1; bus.presentType = 2'd0; step();
        chk("lives_sat", bus.lives, 7);

        // Levels
        bus.fireKey = 1; step();
        bus.ballsCleared = 1; step();
        chk("lvl_done", bus.gameState, 3);
        chk("lvl_done_vis", bus.playerVisible, 0);
        bus.startKey = 1; step();
        chk("lvl1_state", bus.gameState, 1);
        chk("lvl1_level", bus.level, 1);
        chk("lvl1_preset", bus.playerReset, 1);
        chk("lvl1_rope", bus.ropeActive, 0);
        bus.ballsCleared = 1; step();
        bus.startKey = 1; step();
        chk("win_state", bus.gameState, 4);
        chk("win_flag", bus.gameWon, 1);
        bus.startKey = 1; step();
        chk("welcome_state", bus.gameState, 0);
        chk("welcome_lives", bus.lives, 3);
        chk("welcome_level", bus.level, 0);
        chk("welcome_won", bus.gameWon, 0);
        chk("welcome_time", bus.gameTime, 0);

        // Lives run out
        bus.startKey = 1; step();
        bus.col_player_ball = 1; step(); secs(3);
        bus.col_player_ball = 1; step(); secs(3);
        bus.col_player_ball = 1; step();
        chk("last_life", bus.lives, 0);
        chk("last_state", bus.gameState, 1);
        step(); chk("game_over", bus.gameState, 4);

        // Mid-play reset
        bus.startKey = 1; step();
        bus.startKey = 1; step();
        secs(2); chk("replay_time", bus.gameTime, 2);
        bus.playerX = 11'd77; bus.fireKey = 1; step();
        bus.col_present = 1; bus.presentType = 2'd1; step();
        resetN = 1'b0; step();
        chk("mid_state", bus.gameState, 0);
        chk("mid_time", bus.gameTime, 0);
        chk("mid_rope", bus.ropeActive, 0);
        chk("mid_ropex", bus.ropeX, 0);
        chk("mid_pu", bus.puActive, 0);
        chk("mid_lives", bus.lives, 3);
        resetN = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
